memory_access: RTL and testbench

//  Y86-64 memory stage: consumes execute results (icode, valE, valA, dst regs, stat), runs at most one

---
 rtl/memory_access.sv | 170 +++++++++++++++++
 tb/tb_memory_access.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Y86-64 memory stage: one data-memory transaction per instruction over a req/ack bus,
// stalling upstream while outstanding and reporting SADR for bad addresses or bus timeouts.
module memory_access #(
    parameter int unsigned MEM_BYTES      = 2048,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        in_valid_i,
    input  logic [3:0]  icode_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valA_i,
    input  logic [3:0]  dstE_i,
    input  logic [3:0]  dstM_i,
    input  logic [2:0]  stat_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [63:0] mem_rdata_i,
    output logic        busy_o,
    output logic        out_valid_o,
    output logic [63:0] valE_o,
    output logic [63:0] valM_o,
    output logic [3:0]  dstE_o,
    output logic [3:0]  dstM_o,
    output logic [2:0]  m_stat_o
);
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [2:0] SAOK     = 3'd1;
    localparam logic [2:0] SADR     = 3'd3;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               we_reg;
    logic [63:0]        addr_reg, wdata_reg;
    logic               rd_pend_reg;
    logic [63:0]        vale_pend_reg;
    logic [3:0]         dste_pend_reg, dstm_pend_reg;
    logic               out_valid_reg;
    logic [63:0]        vale_reg, valm_reg;
    logic [3:0]         dste_reg, dstm_reg;
    logic [2:0]         stat_reg;

    logic               is_read, is_write, mem_op, addr_legal, accept, start_req, timeout;
    logic [63:0]        addr_dec;
    logic [64:0]        addr_end;
    logic [2:0]         imm_stat;

    always_comb begin
        is_read    = (icode_i == I_MRMOVQ) || (icode_i == I_POPQ) || (icode_i == I_RET);
        is_write   = (icode_i == I_RMMOVQ) || (icode_i == I_PUSHQ) || (icode_i == I_CALL);
        mem_op     = is_read || is_write;
        addr_dec   = ((icode_i == I_POPQ) || (icode_i == I_RET)) ? valA_i : valE_i;
        // 65-bit sum so an address near 2^64 wraps into an illegal result, not a small one
        addr_end   = {1'b0, addr_dec} + 65'd8;
        addr_legal = addr_end <= 65'(MEM_BYTES);
        accept     = in_valid_i && (state_reg == IDLE);
        start_req  = accept && mem_op && (stat_i == SAOK) && addr_legal;
        timeout    = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
        if (stat_i != SAOK)
            imm_stat = stat_i;
        else if (mem_op)
            imm_stat = SADR;
        else
            imm_stat = SAOK;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_req) state_next = REQ;
            REQ:     if (mem_ack_i || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rd_pend_reg   <= 1'b0;
            vale_pend_reg <= '0;
            dste_pend_reg <= RNONE;
            dstm_pend_reg <= RNONE;
            out_valid_reg <= 1'b0;
            vale_reg      <= '0;
            valm_reg      <= '0;
            dste_reg      <= RNONE;
            dstm_reg      <= RNONE;
            stat_reg      <= SAOK;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_req) begin
                        cnt_reg       <= '0;
                        we_reg        <= is_write;
                        addr_reg      <= addr_dec;
                        wdata_reg     <= valA_i;
                        rd_pend_reg   <= is_read;
                        vale_pend_reg <= valE_i;
                        dste_pend_reg <= dstE_i;
                        dstm_pend_reg <= dstM_i;
                    end else if (accept) begin
                        out_valid_reg <= 1'b1;
                        vale_reg      <= valE_i;
                        valm_reg      <= '0;
                        dste_reg      <= dstE_i;
                        dstm_reg      <= (imm_stat == SAOK) ? dstM_i : RNONE;
                        stat_reg      <= imm_stat;
                    end
                end
                REQ: begin
                    // ack on the final counted cycle still completes normally
                    if (mem_ack_i) begin
                        out_valid_reg <= 1'b1;
                        vale_reg      <= vale_pend_reg;
                        valm_reg      <= rd_pend_reg ? mem_rdata_i : 64'd0;
                        dste_reg      <= dste_pend_reg;
                        dstm_reg      <= dstm_pend_reg;
                        stat_reg      <= SAOK;
                    end else if (timeout) begin
                        out_valid_reg <= 1'b1;
                        vale_reg      <= vale_pend_reg;
                        valm_reg      <= '0;
                        dste_reg      <= dste_pend_reg;
                        dstm_reg      <= RNONE;
                        stat_reg      <= SADR;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_o   = (state_reg == REQ);
    assign mem_we_o    = we_reg;
    assign mem_addr_o  = addr_reg;
    assign mem_wdata_o = wdata_reg;
    assign busy_o      = (state_reg != IDLE);
    assign out_valid_o = out_valid_reg;
    assign valE_o      = vale_reg;
    assign valM_o      = valm_reg;
    assign dstE_o      = dste_reg;
    assign dstM_o      = dstm_reg;
    assign m_stat_o    = stat_reg;
endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: each transaction checks request count, latency,
// bus fields and write-back outputs against hand-computed values.
module tb_memory_access;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        in_valid_i;
    logic [3:0]  icode_i;
    logic [63:0] valE_i, valA_i;
    logic [3:0]  dstE_i, dstM_i;
    logic [2:0]  stat_i;
    logic        mem_req_o, mem_we_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [63:0] mem_rdata_i;
    logic        busy_o, out_valid_o;
    logic [63:0] valE_o, valM_o;
    logic [3:0]  dstE_o, dstM_o;
    logic [2:0]  m_stat_o;

    int tests_run = 0;
    int tests_failed = 0;

    // per-transaction observations
    int          rc, lat;
    logic        busy_seen, unstable;
    logic        we_seen;
    logic [63:0] addr_seen, wdata_seen;

    memory_access #(.MEM_BYTES(2048), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .icode_i(icode_i),
        .valE_i(valE_i), .valA_i(valA_i), .dstE_i(dstE_i), .dstM_i(dstM_i), .stat_i(stat_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .out_valid_o(out_valid_o), .valE_o(valE_o), .valM_o(valM_o),
        .dstE_o(dstE_o), .dstM_o(dstM_o), .m_stat_o(m_stat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one instruction; ack_at = 1-based request cycle on which ack is raised (0 = never).
    task automatic run_txn(input string name, input logic [3:0] icode, input logic [63:0] vale,
                           input logic [63:0] vala, input logic [3:0] dste, input logic [3:0] dstm,
                           input logic [2:0] stat, input int ack_at, input logic [63:0] rdata);
        @(negedge clk_i);
        in_valid_i = 1'b1; icode_i = icode; valE_i = vale; valA_i = vala;
        dstE_i = dste; dstM_i = dstm; stat_i = stat;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        rc = 0; lat = -1; busy_seen = 1'b0; unstable = 1'b0;
        we_seen = 1'b0; addr_seen = '0; wdata_seen = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_i);
            if (busy_o) busy_seen = 1'b1;
            if (out_valid_o) begin
                lat = i;
                mem_ack_i = 1'b0;
                break;
            end
            if (mem_req_o) begin
                rc++;
                if (rc == 1) begin
                    we_seen = mem_we_o; addr_seen = mem_addr_o; wdata_seen = mem_wdata_o;
                end else if (mem_we_o !== we_seen || mem_addr_o !== addr_seen ||
                             mem_wdata_o !== wdata_seen) begin
                    unstable = 1'b1;
                end
            end
            mem_ack_i   = mem_req_o && (ack_at != 0) && (rc == ack_at);
            mem_rdata_i = mem_ack_i ? rdata : 64'h0;
        end
        mem_ack_i = 1'b0;
        $display("[TB] txn %s: req_cycles=%0d latency=%0d stat=%0d valE=0x%0h valM=0x%0h dstE=%0h dstM=%0h",
                 name, rc, lat, m_stat_o, valE_o, valM_o, dstE_o, dstM_o);
    endtask

    initial begin
        rst_n_i = 1'b0; in_valid_i = 1'b0; icode_i = '0; valE_i = '0; valA_i = '0;
        dstE_i = 4'hF; dstM_i = 4'hF; stat_i = 3'd1; mem_ack_i = 1'b0; mem_rdata_i = '0;
        #12;
        check("rst_req", mem_req_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_outv", out_valid_o, 0);
        check("rst_valE", valE_o, 0);
        check("rst_dstE", dstE_o, 4'hF);
        check("rst_dstM", dstM_o, 4'hF);
        check("rst_stat", m_stat_o, 1);
        @(negedge clk_i) rst_n_i = 1'b1;

        // MRMOVQ 0x100, ack on second request cycle
        run_txn("mrmovq", 4'h5, 64'h100, 64'h0, 4'hF, 4'h3, 3'd1, 2, 64'hDEADBEEF);
        check("mr_rc", rc, 2);
        check("mr_lat", lat, 3);
        check("mr_addr", addr_seen, 64'h100);
        check("mr_we", we_seen, 0);
        check("mr_valM", valM_o, 64'hDEADBEEF);
        check("mr_stat", m_stat_o, 1);
        check("mr_dstM", dstM_o, 4'h3);
        @(negedge clk_i);
        check("mr_pulse", out_valid_o, 0);
        check("mr_hold", valM_o, 64'hDEADBEEF);
        check("mr_idle", busy_o, 0);

        // RMMOVQ store, ack on third cycle
        run_txn("rmmovq", 4'h4, 64'h08, 64'h55, 4'hF, 4'hF, 3'd1, 3, 64'h1234);
        check("rm_rc", rc, 3);
        check("rm_we", we_seen, 1);
        check("rm_addr", addr_seen, 64'h08);
        check("rm_wdata", wdata_seen, 64'h55);
        check("rm_stable", unstable, 0);
        check("rm_valM", valM_o, 0);
        check("rm_valE", valE_o, 64'h08);

        // OPQ: no memory, no stall
        run_txn("opq", 4'h6, 64'h7, 64'h0, 4'h2, 4'hF, 3'd1, 0, 64'h0);
        check("op_rc", rc, 0);
        check("op_lat", lat, 1);
        check("op_busy", busy_seen, 0);
        check("op_valE", valE_o, 64'h7);
        check("op_dstE", dstE_o, 4'h2);

        // Boundary addresses
        run_txn("mr_2044", 4'h5, 64'd2044, 64'h0, 4'hF, 4'h5, 3'd1, 1, 64'h99);
        check("oob_rc", rc, 0);
        check("oob_lat", lat, 1);
        check("oob_stat", m_stat_o, 3);
        check("oob_dstM", dstM_o, 4'hF);
        check("oob_valM", valM_o, 0);
        run_txn("mr_wrap", 4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'hF, 4'h5, 3'd1, 1, 64'h99);
        check("wrap_rc", rc, 0);
        check("wrap_stat", m_stat_o, 3);
        run_txn("mr_2040", 4'h5, 64'd2040, 64'h0, 4'hF, 4'h6, 3'd1, 1, 64'hABC);
        check("edge_rc", rc, 1);
        check("edge_stat", m_stat_o, 1);
        check("edge_valM", valM_o, 64'hABC);

        // POPQ takes its address from valA
        run_txn("popq", 4'hB, 64'h38, 64'h30, 4'h4, 4'h7, 3'd1, 1, 64'h77);
        check("pop_addr", addr_seen, 64'h30);
        check("pop_valM", valM_o, 64'h77);
        check("pop_valE", valE_o, 64'h38);
        check("pop_dstM", dstM_o, 4'h7);

        // Timeout, and ack on the final cycle
        run_txn("push_to", 4'hA, 64'h200, 64'h11, 4'h4, 4'hF, 3'd1, 0, 64'h0);
        check("to_rc", rc, 16);
        check("to_lat", lat, 17);
        check("to_stat", m_stat_o, 3);
        run_txn("push_ack16", 4'hA, 64'h200, 64'h11, 4'h4, 4'hF, 3'd1, 16, 64'h0);
        check("a16_rc", rc, 16);
        check("a16_stat", m_stat_o, 1);

        // Reset in the middle of a request
        @(negedge clk_i);
        in_valid_i = 1'b1; icode_i = 4'hA; valE_i = 64'h100; valA_i = 64'h1; stat_i = 3'd1;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        @(negedge clk_i);
        check("mid_req", mem_req_o, 1);
        #2 rst_n_i = 1'b0;
        #1;
        check("mid_rst_req", mem_req_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_outv", out_valid_o, 0);
        $display("[TB] txn reset_mid_req: req=%0d busy=%0d", mem_req_o, busy_o);
        @(negedge clk_i) rst_n_i = 1'b1;

        // Halted POPQ passes status, no request
        run_txn("popq_hlt", 4'hB, 64'h18, 64'h10, 4'h4, 4'h7, 3'd2, 1, 64'h55);
        check("hlt_rc", rc, 0);
        check("hlt_lat", lat, 1);
        check("hlt_stat", m_stat_o, 2);
        check("hlt_dstM", dstM_o, 4'hF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
